// File: rtl/aes_pkg.sv
// Purpose : shared AES-128 constants and round-transform helpers, used by both
//           the unrolled and the iterative encryption engines.
// Latency : n/a (package: constants, types and pure combinational functions).
// Backpr. : n/a.
// Contents: SBOX (256x8), RCON (10x8), FSM state type/constants,
//           xtime, sub_bytes, shift_rows, mix_columns.
// Byte order: bit 127 is byte 0 (FIPS-197); byte k = column k/4, row k%4.
package aes_pkg;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants for rounds 1..10 (element 0 is round 1).
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t IDLE  = 2'd0;
  localparam fsm_state_t ROUND = 2'd1;
  localparam fsm_state_t DONE  = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Row r of the output takes column (c+r) mod 4 of the input.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Purpose : one AES-128 key-expansion step (round key i -> round key i+1).
// Latency : combinational.
// Backpr. : none (pure function of its inputs).
// Ports   : key_i  current 128-bit round key
//           rcon_i round constant byte for the round being produced
//           key_o  next 128-bit round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  // RotWord then SubWord on the last word; rcon lands in the MSB byte.
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
              ^ {rcon_i, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_iter_sequencer.sv
// Purpose : iterative AES-128 encryptor; one shared round datapath and one
//           on-the-fly key step reused over 11 cycles (ARK + 10 rounds).
// Latency : out_valid rises on the 11th clock edge counting the accept edge.
// Backpr. : DONE (and out_block) held until out_ready; in_ready low meanwhile.
// Ports   : clk/rst (sync, active-high); in_valid/in_ready/in_block/in_key;
//           out_valid/out_ready/out_block; busy (high while in ROUND).
// Option  : define AES_BACK2BACK_EN to accept a new block in the same cycle
//           the result handshakes (one block per 11 cycles sustained).
module aes_iter_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR     = 10,
  parameter int unsigned RCNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  fsm_state_t          fsm_q, fsm_d;
  logic [RCNT_W-1:0]   rnd_q, rnd_d;
  logic [127:0]        state_q, state_d;
  logic [127:0]        key_q, key_d;
  logic [127:0]        out_q, out_d;

  logic [7:0]          rcon_sel;
  logic [127:0]        key_next;
  logic [127:0]        sr_state;
  logic                last_round;
  logic                accept;

  always_comb begin
    rcon_sel = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (int'(rnd_q) == i) rcon_sel = RCON[i-1];
    end
  end

  aes_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (rcon_sel),
    .key_o  (key_next)
  );

  assign sr_state   = shift_rows(sub_bytes(state_q));
  assign last_round = (rnd_q == RCNT_W'(NR));

  always_comb begin
    in_ready = 1'b0;
    case (fsm_q)
      IDLE: in_ready = 1'b1;
`ifdef AES_BACK2BACK_EN
      // Result slot frees this very cycle, so a new block can enter.
      DONE: in_ready = out_ready;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == ROUND);
  assign out_block = out_q;

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    key_d   = key_q;
    out_d   = out_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = in_block ^ in_key;
          key_d   = in_key;
          rnd_d   = RCNT_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        key_d = key_next;
        rnd_d = rnd_q + RCNT_W'(1);
        if (last_round) begin
          out_d = sr_state ^ key_next;
          fsm_d = DONE;
        end else begin
          state_d = mix_columns(sr_state) ^ key_next;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
          if (accept) begin
            state_d = in_block ^ in_key;
            key_d   = in_key;
            rnd_d   = RCNT_W'(1);
            fsm_d   = ROUND;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      key_q   <= key_d;
      out_q   <= out_d;
    end
  end

endmodule
